// File: rtl/pwm_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_sequencer
//
// Configurable PWM generator with a prescaler, a period counter and a
// double-buffered configuration. A new configuration offered while running
// is parked in shadow registers and only becomes active on the next period
// boundary, so a waveform period is never cut short or mixed.
//
// Parameters
//   DIV_W       width of the prescaler ratio field
//   CNT_W       width of the period and duty fields
//
// Ports
//   cLocK       clock, all state changes on the rising edge
//   Reset_n     asynchronous active-low reset
//   en          run enable; low freezes the counters and forces pwm_out low
//   stop        one-cycle request to go back to IDLE, drops any pending config
//   cfg_valid   configuration offer, held until accepted
//   cfg_ready   configuration can be accepted this cycle
//   cfg_div     prescaler ratio, one tick every cfg_div+1 clocks
//   cfg_period  period length of cfg_period+1 ticks
//   cfg_duty    number of high ticks per period
//   pwm_out     PWM waveform
//   period_end  one-cycle pulse on the last clock of each period
//   busy        high while a configuration is active (RUN or PEND)
// ---------------------------------------------------------------------------
module pwm_sequencer #(
    parameter int DIV_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             cLocK,
    input  logic             Reset_n,
    input  logic             en,
    input  logic             stop,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             pwm_out,
    output logic             period_end,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DIV_W-1:0] pre_cnt;
    logic [CNT_W-1:0] per_cnt;

    logic [DIV_W-1:0] div_act;
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_act;
    logic [DIV_W-1:0] div_shd;
    logic [CNT_W-1:0] period_shd;
    logic [CNT_W-1:0] duty_shd;

    logic accept;
    logic tick;
    logic per_last;
    logic load_act;
    logic load_shd;
    logic swap;
    logic clr_cnt;

    // State register: the only place the FSM state is stored.
    always_ff @(posedge cLocK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Output decode and next-state logic. Everything here is derived from
    // registered state plus the current inputs. stop overrides every other
    // event, which is also why it masks cfg_ready: an offer arriving together
    // with stop must never be taken.
    always_comb begin
        state_nxt  = state;
        load_act   = 1'b0;
        load_shd   = 1'b0;
        swap       = 1'b0;
        clr_cnt    = 1'b0;

        busy       = (state != IDLE);
        cfg_ready  = (state != PEND) && !stop;
        accept     = cfg_valid && cfg_ready;
        tick       = busy && en && (pre_cnt == div_act);
        per_last   = (per_cnt == period_act);
        period_end = tick && per_last;
        pwm_out    = busy && en && (per_cnt < duty_act);

        if (stop) begin
            state_nxt = IDLE;
            clr_cnt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = RUN;
                        load_act  = 1'b1;
                        clr_cnt   = 1'b1;
                    end
                end
                RUN: begin
                    // An accept on the period_end cycle still only lands in
                    // the shadow, so it waits a full period before applying.
                    if (accept) begin
                        state_nxt = PEND;
                        load_shd  = 1'b1;
                    end
                end
                PEND: begin
                    if (period_end) begin
                        state_nxt = RUN;
                        swap      = 1'b1;
                        clr_cnt   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    clr_cnt   = 1'b1;
                end
            endcase
        end
    end

    // Prescaler and period counters. They only move while running and
    // enabled, and compare for equality against the active maxima so they
    // can never run past them.
    always_ff @(posedge cLocK or negedge Reset_n) begin
        if (!Reset_n) begin
            pre_cnt <= '0;
            per_cnt <= '0;
        end else if (clr_cnt) begin
            pre_cnt <= '0;
            per_cnt <= '0;
        end else if (busy && en) begin
            if (tick) begin
                pre_cnt <= '0;
                if (per_last) begin
                    per_cnt <= '0;
                end else begin
                    per_cnt <= per_cnt + 1'b1;
                end
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Active and shadow configuration. stop clears the shadow so a pending
    // configuration cannot leak into a later run; the active copy is left
    // alone because it is ignored in IDLE and overwritten by the next accept.
    always_ff @(posedge cLocK or negedge Reset_n) begin
        if (!Reset_n) begin
            div_act    <= '0;
            period_act <= '0;
            duty_act   <= '0;
            div_shd    <= '0;
            period_shd <= '0;
            duty_shd   <= '0;
        end else if (stop) begin
            div_shd    <= '0;
            period_shd <= '0;
            duty_shd   <= '0;
        end else if (load_act) begin
            div_act    <= cfg_div;
            period_act <= cfg_period;
            duty_act   <= cfg_duty;
        end else if (load_shd) begin
            div_shd    <= cfg_div;
            period_shd <= cfg_period;
            duty_shd   <= cfg_duty;
        end else if (swap) begin
            div_act    <= div_shd;
            period_act <= period_shd;
            duty_act   <= duty_shd;
        end
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_sequencer
//
// Self-checking bench for pwm_sequencer. Each test pushes the expected
// per-clock output vector {pwm_out, period_end, busy, cfg_ready} into a
// scoreboard queue, drives its stimulus, and pops/compares one entry per
// clock. Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pwm_sequencer;

    localparam int DIV_W = 4;
    localparam int CNT_W = 8;

    logic             cLocK;
    logic             Reset_n;
    logic             en;
    logic             stop;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;
    logic             pwm_out;
    logic             period_end;
    logic             busy;

    typedef struct packed {
        logic pwm;
        logic pe;
        logic bsy;
        logic rdy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pwm_sequencer #(
        .DIV_W(DIV_W),
        .CNT_W(CNT_W)
    ) dut (
        .cLocK     (cLocK),
        .Reset_n   (Reset_n),
        .en        (en),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_period(cfg_period),
        .cfg_duty  (cfg_duty),
        .pwm_out   (pwm_out),
        .period_end(period_end),
        .busy      (busy)
    );

    // Free-running 10-unit clock.
    initial begin
        cLocK = 1'b0;
        forever #5 cLocK = ~cLocK;
    end

    // Watchdog so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected waveform of whole periods, built tick by tick from the
    // configuration: duty compares against the tick index within the period.
    task automatic push_wave(input int div, input int period, input int duty, input int nper);
        exp_t e;
        for (int p = 0; p < nper; p++) begin
            for (int per = 0; per <= period; per++) begin
                for (int pre = 0; pre <= div; pre++) begin
                    e.pwm = (per < duty);
                    e.pe  = (per == period) && (pre == div);
                    e.bsy = 1'b1;
                    e.rdy = 1'b1;
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic clear_ready(input int first, input int last);
        exp_t t;
        for (int i = first; i <= last; i++) begin
            t     = sb[i];
            t.rdy = 1'b0;
            sb[i] = t;
        end
    endtask

    // Offer one configuration for exactly one edge (caller ensures ready).
    task automatic applyStimulus(input int div, input int period, input int duty);
        cfg_valid  = 1'b1;
        cfg_div    = DIV_W'(div);
        cfg_period = CNT_W'(period);
        cfg_duty   = CNT_W'(duty);
        @(posedge cLocK);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        @(posedge cLocK);
        #1;
        stop = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] obs;
        #3;
        obs = {pwm_out, period_end, busy, cfg_ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_held: got %b want %b (pwm,pe,busy,rdy)", obs, 4'b0001);
        end
        repeat (2) @(posedge cLocK);
        #1;
        Reset_n = 1'b1;
        @(negedge cLocK);
        obs = {pwm_out, period_end, busy, cfg_ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL reset_release: got %b want %b (pwm,pe,busy,rdy)", obs, 4'b0001);
        end
        @(posedge cLocK);
        #1;
    endtask

    task automatic test_basic();
        exp_t e;
        logic [3:0] obs;
        int n;
        applyStimulus(1, 3, 2);
        push_wave(1, 3, 2, 3);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge cLocK);
            e   = sb.pop_front();
            obs = {pwm_out, period_end, busy, cfg_ready};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL basic cycle %0d: got %b want %b (pwm,pe,busy,rdy)", i, obs, e);
            end
            @(posedge cLocK);
            #1;
        end
    endtask

    task automatic test_deferred();
        exp_t e;
        logic [3:0] obs;
        int n;
        push_wave(1, 3, 2, 1);
        push_wave(1, 3, 1, 2);
        clear_ready(3, 7);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 2) begin
                cfg_valid  = 1'b1;
                cfg_div    = DIV_W'(1);
                cfg_period = CNT_W'(3);
                cfg_duty   = CNT_W'(1);
            end
            if (i == 3) cfg_valid = 1'b0;
            @(negedge cLocK);
            e   = sb.pop_front();
            obs = {pwm_out, period_end, busy, cfg_ready};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL deferred cycle %0d: got %b want %b (pwm,pe,busy,rdy)", i, obs, e);
            end
            @(posedge cLocK);
            #1;
        end
    endtask

    task automatic test_accept_at_boundary();
        exp_t e;
        logic [3:0] obs;
        int n;
        push_wave(1, 3, 1, 2);
        push_wave(1, 3, 3, 1);
        clear_ready(8, 15);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 7) begin
                cfg_valid  = 1'b1;
                cfg_div    = DIV_W'(1);
                cfg_period = CNT_W'(3);
                cfg_duty   = CNT_W'(3);
            end
            if (i == 8) cfg_valid = 1'b0;
            @(negedge cLocK);
            e   = sb.pop_front();
            obs = {pwm_out, period_end, busy, cfg_ready};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL boundary_accept cycle %0d: got %b want %b (pwm,pe,busy,rdy)", i, obs, e);
            end
            @(posedge cLocK);
            #1;
        end
    endtask

    task automatic test_stop_collision();
        logic [3:0] obs;
        stop       = 1'b1;
        cfg_valid  = 1'b1;
        cfg_div    = DIV_W'(2);
        cfg_period = CNT_W'(5);
        cfg_duty   = CNT_W'(1);
        @(negedge cLocK);
        obs = {pwm_out, period_end, busy, cfg_ready};
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL stop_with_valid: got %b want %b (pwm,pe,busy,rdy)", obs, 4'b1010);
        end
        @(posedge cLocK);
        #1;
        stop      = 1'b0;
        cfg_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge cLocK);
            obs = {pwm_out, period_end, busy, cfg_ready};
            checks++;
            if (obs !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL stop_idle cycle %0d: got %b want %b (pwm,pe,busy,rdy)", i, obs, 4'b0001);
            end
            @(posedge cLocK);
            #1;
        end
    endtask

    task automatic test_duty_extremes();
        exp_t e;
        logic [3:0] obs;
        int n;
        for (int k = 0; k < 2; k++) begin
            applyStimulus(0, 4, (k == 0) ? 0 : 9);
            push_wave(0, 4, (k == 0) ? 0 : 9, 2);
            n = sb.size();
            for (int i = 0; i < n; i++) begin
                @(negedge cLocK);
                e   = sb.pop_front();
                obs = {pwm_out, period_end, busy, cfg_ready};
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("[TB] FAIL duty_extreme%0d cycle %0d: got %b want %b (pwm,pe,busy,rdy)", k, i, obs, e);
                end
                @(posedge cLocK);
                #1;
            end
            do_stop();
        end
    endtask

    task automatic test_freeze();
        exp_t e;
        exp_t f;
        logic [3:0] obs;
        int n;
        applyStimulus(1, 3, 2);
        push_wave(1, 3, 2, 2);
        f = '{pwm: 1'b0, pe: 1'b0, bsy: 1'b1, rdy: 1'b1};
        for (int j = 0; j < 3; j++) sb.insert(3, f);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            if (i == 3) en = 1'b0;
            if (i == 6) en = 1'b1;
            @(negedge cLocK);
            e   = sb.pop_front();
            obs = {pwm_out, period_end, busy, cfg_ready};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL freeze cycle %0d: got %b want %b (pwm,pe,busy,rdy)", i, obs, e);
            end
            @(posedge cLocK);
            #1;
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        logic [3:0] obs;
        int n;
        applyStimulus(0, 1, 1);
        @(negedge cLocK);
        obs = {pwm_out, period_end, busy, cfg_ready};
        checks++;
        if (obs !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL pend_before_reset: got %b want %b (pwm,pe,busy,rdy)", obs, 4'b1010);
        end
        #2;
        Reset_n = 1'b0;
        #1;
        obs = {pwm_out, period_end, busy, cfg_ready};
        checks++;
        if (obs !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL async_reset_immediate: got %b want %b (pwm,pe,busy,rdy)", obs, 4'b0001);
        end
        @(posedge cLocK);
        #1;
        Reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge cLocK);
            obs = {pwm_out, period_end, busy, cfg_ready};
            checks++;
            if (obs !== 4'b0001) begin
                errors++;
                $display("[TB] FAIL after_reset_idle cycle %0d: got %b want %b (pwm,pe,busy,rdy)", i, obs, 4'b0001);
            end
            @(posedge cLocK);
            #1;
        end
        applyStimulus(0, 2, 1);
        push_wave(0, 2, 1, 2);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge cLocK);
            e   = sb.pop_front();
            obs = {pwm_out, period_end, busy, cfg_ready};
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL restart cycle %0d: got %b want %b (pwm,pe,busy,rdy)", i, obs, e);
            end
            @(posedge cLocK);
            #1;
        end
    endtask

    // Test sequence; each test leaves the design at a clean period boundary
    // or in IDLE for the next one.
    initial begin
        Reset_n    = 1'b0;
        en         = 1'b1;
        stop       = 1'b0;
        cfg_valid  = 1'b0;
        cfg_div    = '0;
        cfg_period = '0;
        cfg_duty   = '0;
        test_reset();
        test_basic();
        test_deferred();
        test_accept_at_boundary();
        test_stop_collision();
        test_duty_extremes();
        test_freeze();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_sequencer.md
PWM_SEQUENCER -- requirements
Module: pwm_sequencer

Interface
REQ-001 Parameter DIV_W, default 4, width of the prescaler ratio field.
REQ-002 Parameter CNT_W, default 8, width of the period and duty fields.
REQ-003 Port cLocK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port Reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port en  input  1  run enable; 0 freezes the counters and forces pwm_out to 0.
REQ-006 Port stop  input  1  one-cycle request to return to IDLE; any pending configuration is discarded.
REQ-007 Port cfg_valid  input  1  configuration offer; held until accepted.
REQ-008 Port cfg_ready  output  1  configuration can be accepted this cycle.
REQ-009 Port cfg_div  input  DIV_W  prescaler ratio; one tick every cfg_div+1 clocks.
REQ-010 Port cfg_period  input  CNT_W  PWM period of cfg_period+1 ticks.
REQ-011 Port cfg_duty  input  CNT_W  number of high ticks per period.
REQ-012 Port pwm_out  output  1  PWM waveform.
REQ-013 Port period_end  output  1  one-cycle pulse on the last clock of each period.
REQ-014 Port busy  output  1  high in RUN or PEND.

Function
REQ-015 There SHALL be three states: IDLE, RUN (active configuration valid) and PEND (RUN with a new configuration held in shadow registers).
REQ-016 cfg_ready SHALL equal (state != PEND) AND NOT stop, decoded combinationally from registered state.
REQ-017 Accept is cfg_valid AND cfg_ready; field values are sampled only on accept.
REQ-018 Accept in IDLE: fields load into the active registers, the prescaler and period counters clear, and the state becomes RUN on the next edge.
REQ-019 Accept in RUN: fields load into the shadow registers and the state becomes PEND; the active configuration is unchanged.
REQ-020 Prescaler pre_cnt: counts 0..div_act while running AND en; tick = running AND en AND (pre_cnt == div_act); pre_cnt wraps to 0 on tick.
REQ-021 Period counter per_cnt: advances only on tick and wraps to 0 on the tick where per_cnt == period_act.
REQ-022 period_end SHALL equal tick AND (per_cnt == period_act).
REQ-023 pwm_out SHALL equal busy AND en AND (per_cnt < duty_act).
REQ-024 Duty cases:
- duty 0 gives a constant low output.
- duty >= period+1 gives a constant high output.
- The comparison is unsigned at CNT_W bits.
REQ-025 PEND and period_end in the same cycle: shadow copies to active, both counters are 0 on the next edge, and the state returns to RUN.
REQ-026 Accept in RUN and period_end in the same cycle: the new configuration goes to shadow and takes effect at the following period end, not the current one.
REQ-027 stop asserted in any state:
- The next state is IDLE.
- Both counters clear.
- The shadow is discarded.
- The active registers keep their values but are unused.
- stop has priority over every other event.
REQ-028 en = 0 in RUN or PEND: counters hold, no tick or period_end occurs, and PEND stays pending.
REQ-029 No arithmetic overflow: counters compare for equality against the configured maxima and never exceed them.

Reset
REQ-030 Reset_n low SHALL immediately set:
- state IDLE;
- pre_cnt, per_cnt, active and shadow registers to 0;
- pwm_out 0, period_end 0, busy 0;
- cfg_ready 1 (when stop is low).
REQ-031 Reset_n asserted mid-period or while PEND SHALL abandon all configuration; operation resumes only after a new accept.
REQ-032 Release of Reset_n is synchronous to cLocK: the first state change is possible on the first rising edge after release.

Verification
REQ-033 Basic waveform: reset, then accept div=1, period=3, duty=2 in IDLE at edge N -> busy at N+1; pwm_out high 4 clocks then low 4 clocks repeating; period_end pulses every 8 clocks.
REQ-034 Deferred update: while running the REQ-033 configuration, offer duty=1 mid-period -> cfg_ready drops and busy stays high; the old waveform completes; the next period is high 2 clocks and low 6 clocks; cfg_ready returns after the boundary.
REQ-035 Duty extremes: div=0, period=4, duty=0 -> pwm_out constantly 0; duty=9 -> constantly 1; period_end every 5 clocks in both cases.
REQ-036 Collision cases: an accept in the same cycle as period_end -> applied one period later. stop together with cfg_valid -> cfg_ready 0, next state IDLE, no accept.
REQ-037 Freeze: en low for 3 clocks mid-period -> pwm_out 0 and counters held; on en high the period resumes at the same per_cnt and finishes 3 clocks late.
REQ-038 Async reset: assert Reset_n low between clock edges while PEND -> outputs at reset values before the next edge; after release, cfg_ready is 1 and state is IDLE.
